// File: rtl/mod_reduce_32.sv
// Digit-serial modular reduction: returns {sum_carry,sum} mod N given {sum_carry,sum} < 2N.
// Optional range checker lane enabled by defining MOD_REDUCE_RANGE_CHK_EN (adds output err).
module mod_reduce_32 #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] sum,
  input  logic             sum_carry,
  input  logic [WIDTH-1:0] modulus,
  output logic             busy,
  output logic             done,
`ifdef MOD_REDUCE_RANGE_CHK_EN
  output logic             err,
`endif
  output logic [WIDTH-1:0] result
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic             borrow_q, borrow_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] mod_q, mod_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [DIGIT-1:0] sum_dig, mod_dig;
  logic [DIGIT:0]   dig_res;
  logic [WIDTH-1:0] diff_cur;
  logic             sel_diff;

  // One digit of a - b - bin; the MSB of the result is the borrow out.
  function automatic logic [DIGIT:0] sub_digit(input logic [DIGIT-1:0] a,
                                               input logic [DIGIT-1:0] b,
                                               input logic             bin);
    return {1'b0, a} - {1'b0, b} - {{DIGIT{1'b0}}, bin};
  endfunction

  always_comb begin
    sum_dig  = sum_q[count_q*DIGIT +: DIGIT];
    mod_dig  = mod_q[count_q*DIGIT +: DIGIT];
    dig_res  = sub_digit(sum_dig, mod_dig, borrow_q);
    // Merge the digit being computed so the last cycle can select without waiting an edge.
    diff_cur = diff_q;
    diff_cur[count_q*DIGIT +: DIGIT] = dig_res[DIGIT-1:0];
    sel_diff = carry_q | ~dig_res[DIGIT];
  end

`ifdef MOD_REDUCE_RANGE_CHK_EN
  logic           borrow2_q, borrow2_d;
  logic           err_q, err_d;
  logic [DIGIT:0] dig2_res;

  always_comb begin
    dig2_res = sub_digit(dig_res[DIGIT-1:0], mod_dig, borrow2_q);
  end
`endif

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    borrow_d = borrow_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    mod_d    = mod_q;
    diff_d   = diff_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
`ifdef MOD_REDUCE_RANGE_CHK_EN
    borrow2_d = borrow2_q;
    err_d     = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          sum_d    = sum;
          carry_d  = sum_carry;
          mod_d    = modulus;
          borrow_d = 1'b0;
          count_d  = '0;
          busy_d   = 1'b1;
          state_d  = SUB;
`ifdef MOD_REDUCE_RANGE_CHK_EN
          borrow2_d = 1'b0;
`endif
        end
      end
      SUB: begin
        diff_d   = diff_cur;
        borrow_d = dig_res[DIGIT];
        count_d  = count_q + CW'(1);
`ifdef MOD_REDUCE_RANGE_CHK_EN
        borrow2_d = dig2_res[DIGIT];
`endif
        if (count_q == LAST) begin
          result_d = sel_diff ? diff_cur : sum_q;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          count_d  = '0;
          state_d  = DONE;
`ifdef MOD_REDUCE_RANGE_CHK_EN
          // Still >= N after one subtraction: either a surviving top bit or diff - N did not borrow.
          err_d = sel_diff & ((carry_q & ~dig_res[DIGIT]) | ~dig2_res[DIGIT]);
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      borrow_q <= 1'b0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      mod_q    <= '0;
      diff_q   <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef MOD_REDUCE_RANGE_CHK_EN
      borrow2_q <= 1'b0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      borrow_q <= borrow_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      mod_q    <= mod_d;
      diff_q   <= diff_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef MOD_REDUCE_RANGE_CHK_EN
      borrow2_q <= borrow2_d;
      err_q     <= err_d;
`endif
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
`ifdef MOD_REDUCE_RANGE_CHK_EN
  assign err    = err_q;
`endif

endmodule

// File: tb/tb_mod_reduce_32.sv
// Directed, table-driven bench for mod_reduce_32 (range-check lane covered when MOD_REDUCE_RANGE_CHK_EN is defined).
module tb_mod_reduce_32;

  localparam int NDIG = 4;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] sum;
  logic        sum_carry;
  logic [31:0] modulus;
  logic        busy;
  logic        done;
  logic [31:0] result;
`ifdef MOD_REDUCE_RANGE_CHK_EN
  logic        err;
`endif

  int checks = 0;
  int errors = 0;

  mod_reduce_32 dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sum       (sum),
    .sum_carry (sum_carry),
    .modulus   (modulus),
    .busy      (busy),
    .done      (done),
`ifdef MOD_REDUCE_RANGE_CHK_EN
    .err       (err),
`endif
    .result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] s;
    logic        c;
    logic [31:0] n;
    logic [31:0] exp_res;
    logic        exp_err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one operation; inputs are scrambled after acceptance to prove they were latched.
  task automatic run_op(input string name, input vec_t v);
    int  cyc;
    bit  busy_ok;
    @(negedge clk);
    sum = v.s; sum_carry = v.c; modulus = v.n; start = 1'b1;
    tick();
    start = 1'b0;
    sum = 32'hDEAD_BEEF; sum_carry = ~v.c; modulus = 32'h1357_9BDF;
    cyc = 0;
    busy_ok = 1'b1;
    while (!done && cyc < 20) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      tick();
      cyc++;
    end
    check({name, " done"}, {31'd0, done}, 32'd1);
    check({name, " latency"}, cyc, NDIG);
    check({name, " busy during op"}, {31'd0, busy_ok}, 32'd1);
    check({name, " busy at done"}, {31'd0, busy}, 32'd0);
    check({name, " result"}, result, v.exp_res);
`ifdef MOD_REDUCE_RANGE_CHK_EN
    check({name, " err"}, {31'd0, err}, {31'd0, v.exp_err});
`endif
    tick();
    check({name, " done pulse width"}, {31'd0, done}, 32'd0);
    check({name, " result hold"}, result, v.exp_res);
  endtask

  vec_t vecs[10];
  int   pulses;

  initial begin
    vecs[0] = '{32'h0000_0005, 1'b0, 32'h0000_0007, 32'h0000_0005, 1'b0};
    vecs[1] = '{32'h0000_0100, 1'b0, 32'h0000_00FF, 32'h0000_0001, 1'b0};
    vecs[2] = '{32'h8000_0001, 1'b0, 32'h8000_0001, 32'h0000_0000, 1'b0};
    vecs[3] = '{32'h0000_0002, 1'b1, 32'hFFFF_FFFF, 32'h0000_0003, 1'b0};
    vecs[4] = '{32'h1234_5678, 1'b1, 32'h0000_0000, 32'h1234_5678, 1'b1};
    vecs[5] = '{32'h0000_0015, 1'b0, 32'h0000_0007, 32'h0000_000E, 1'b1};
    vecs[6] = '{32'h0000_0006, 1'b0, 32'h0000_0007, 32'h0000_0006, 1'b0};
    vecs[7] = '{32'hFFFF_FFF0, 1'b0, 32'h8000_0000, 32'h7FFF_FFF0, 1'b0};
    vecs[8] = '{32'h9ABC_DEF0, 1'b0, 32'h9ABC_DEF1, 32'h9ABC_DEF0, 1'b0};
    vecs[9] = '{32'h0000_0001, 1'b1, 32'h8000_0001, 32'h8000_0000, 1'b0};

    rst = 1'b1; start = 1'b0; sum = '0; sum_carry = 1'b0; modulus = '0;
    tick();
    tick();
    check("reset result", result, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
`ifdef MOD_REDUCE_RANGE_CHK_EN
    check("reset err", {31'd0, err}, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done || busy) pulses++;
    end
    check("idle no activity", pulses, 0);

    for (int i = 0; i < 10; i++) run_op($sformatf("vec%0d", i), vecs[i]);

    // start held high through SUB and DONE must not queue a second operation
    @(negedge clk);
    sum = 32'h0000_0100; sum_carry = 1'b0; modulus = 32'h0000_00FF; start = 1'b1;
    tick();
    sum = 32'h0000_0050;
    pulses = 0;
    for (int i = 0; i < NDIG + 1; i++) begin
      tick();
      if (done) pulses++;
    end
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done) pulses++;
    end
    check("ignored start pulses", pulses, 1);
    check("ignored start result", result, 32'h0000_0001);
    check("ignored start idle busy", {31'd0, busy}, 32'd0);

    // abort with reset at count=2
    @(negedge clk);
    sum = 32'h0000_0015; sum_carry = 1'b0; modulus = 32'h0000_0007; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort done", {31'd0, done}, 32'd0);
    check("abort result", result, 32'd0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done) pulses++;
    end
    check("abort no done", pulses, 0);
    run_op("after abort", vecs[7]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
